// File: rtl/node_t30.sv
// node_t30: stacking mesh node.
// LIFO fed by four neighbors, top word offered round-robin.
module node_t30 #(
  parameter int DEPTH = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [10:0] in0,
  input  logic signed [10:0] in1,
  input  logic signed [10:0] in2,
  input  logic signed [10:0] in3,
  input  logic [3:0]         ready,
  input  logic [3:0]         done,
  output logic signed [10:0] outData,
  output logic [3:0]         recv,
  output logic [3:0]         send
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]      cnt;
  logic [3:0]         armed;
  logic [1:0]         op;
  logic signed [10:0] mem [DEPTH];

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [3:0]         cand;
  logic signed [10:0] din;
  logic [AW-1:0]      top;
  logic [AW-1:0]      wa;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign top   = AW'(cnt - CW'(1));
  assign cand  = ready & armed & {4{~full}};
  assign push  = |recv;
  assign pop   = (|done) & ~empty;
  assign wa    = pop ? top : AW'(cnt);

  // lowest armed writer wins the accept slot
  always_comb begin
    recv = 4'b0000;
    priority case (1'b1)
      cand[0]: recv = 4'b0001;
      cand[1]: recv = 4'b0010;
      cand[2]: recv = 4'b0100;
      cand[3]: recv = 4'b1000;
      default: recv = 4'b0000;
    endcase
  end

  // select the accepted word
  always_comb begin
    din = '0;
    unique case (1'b1)
      recv[0]: din = in0;
      recv[1]: din = in1;
      recv[2]: din = in2;
      recv[3]: din = in3;
      default: din = '0;
    endcase
  end

  // offer top only on quiet cycles
  always_comb begin
    send = 4'b0000;
    if (!empty && done == 4'b0000 && recv == 4'b0000)
      send = 4'b0001 << op;
  end

  // top of stack or zero when empty
  always_comb begin
    outData = '0;
    if (!empty)
      outData = mem[top];
  end

  // a writer must hold ready one cycle before it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      armed <= 4'b0000;
    else
      armed <= ready & ~recv;
  end

  // free-running offer pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op <= 2'd0;
    else
      op <= op + 2'd1;
  end

  // occupancy; push+pop replaces top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (push && !pop)
      cnt <= cnt + CW'(1);
    else if (pop && !push)
      cnt <= cnt - CW'(1);
  end

  // storage needs no reset, cnt gates visibility
  always_ff @(posedge clk) begin
    if (push)
      mem[wa] <= din;
  end

endmodule

// File: tb/tb_node_t30.sv
// tb_node_t30: directed scoreboard bench for node_t30.
// Default-depth node plus a DEPTH=2 node for the full case.
module tb_node_t30;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         rdy [2];
  logic [3:0]         dn  [2];
  logic signed [10:0] din [2][4];
  logic signed [10:0] od  [2];
  logic [3:0]         rc  [2];
  logic [3:0]         sd  [2];
  logic [1:0]         mop;
  logic [3:0]         o;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  node_t30 u0 (
    .clk(clk), .rst_n(rst_n),
    .in0(din[0][0]), .in1(din[0][1]),
    .in2(din[0][2]), .in3(din[0][3]),
    .ready(rdy[0]), .done(dn[0]),
    .outData(od[0]), .recv(rc[0]), .send(sd[0])
  );

  node_t30 #(.DEPTH(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in0(din[1][0]), .in1(din[1][1]),
    .in2(din[1][2]), .in3(din[1][3]),
    .ready(rdy[1]), .done(dn[1]),
    .outData(od[1]), .recv(rc[1]), .send(sd[1])
  );

  // expected offer pointer
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mop <= 2'd0;
    else
      mop <= mop + 2'd1;
  end

  task automatic want(string t, logic [31:0] v);
    q.push_back('{t, v});
  endtask

  task automatic got(logic [31:0] obs);
    exp_t e;
    ncmp++;
    if (q.size() == 0) begin
      nfail++;
      $error("FAIL sb_underflow obs=%0h exp=none", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        nfail++;
        $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic push(int s, int p, logic signed [10:0] v);
    rdy[s][p] = 1'b1;
    din[s][p] = v;
    want("push_wait", 0);
    #1 got(rc[s]);
    @(negedge clk);
    want("push_acc", 32'(4'b0001 << p));
    #1 got(rc[s]);
    @(negedge clk);
    rdy[s][p] = 1'b0;
  endtask

  task automatic pop(int s, logic [10:0] v);
    logic [3:0] so;
    want("top", {21'd0, v});
    #1 got({21'd0, od[s]});
    want("offer", 32'(4'b0001 << mop));
    got(sd[s]);
    so = sd[s];
    @(negedge clk);
    dn[s] = so;
    want("send_mute", 0);
    #1 got(sd[s]);
    @(negedge clk);
    dn[s] = 4'b0000;
  endtask

  task automatic empty_ck(int s);
    want("empty_data", 0);
    #1 got({21'd0, od[s]});
    want("empty_send", 0);
    got(sd[s]);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rdy[s] = 4'b0000;
      dn[s]  = 4'b0000;
      for (int p = 0; p < 4; p++)
        din[s][p] = '0;
    end
    rdy[0] = 4'b0001;

    // reset state, ready ignored
    @(negedge clk);
    @(negedge clk);
    want("rst_data", 0);
    #1 got({21'd0, od[0]});
    want("rst_recv", 0);
    got(rc[0]);
    want("rst_send", 0);
    got(sd[0]);
    want("rst_data1", 0);
    got({21'd0, od[1]});
    @(negedge clk);
    rdy[0] = 4'b0000;
    rst_n  = 1'b1;

    // single push then pop on port 2 offer
    push(0, 0, 11'sd5);
    want("top5", 5);
    #1 got({21'd0, od[0]});
    @(negedge clk);
    for (int k = 0; k < 4 && mop != 2'd2; k++)
      @(negedge clk);
    pop(0, 11'd5);
    empty_ck(0);

    // LIFO order
    push(0, 1, 11'sd1);
    push(0, 1, 11'sd2);
    push(0, 1, 11'sd3);
    pop(0, 11'd3);
    pop(0, 11'd2);
    pop(0, 11'd1);
    empty_ck(0);

    // done while empty is ignored
    dn[0] = 4'b0001;
    want("empty_done_send", 0);
    #1 got(sd[0]);
    @(negedge clk);
    dn[0] = 4'b0000;
    empty_ck(0);
    push(0, 2, 11'sd11);
    pop(0, 11'd11);
    empty_ck(0);

    // contention between ports 1 and 2
    rdy[0] = 4'b0110;
    din[0][1] = 11'sd10;
    din[0][2] = 11'sd20;
    want("cont_wait", 0);
    #1 got(rc[0]);
    @(negedge clk);
    want("cont_p1", 4'b0010);
    #1 got(rc[0]);
    @(negedge clk);
    want("cont_p2", 4'b0100);
    #1 got(rc[0]);
    @(negedge clk);
    rdy[0] = 4'b0000;
    pop(0, 11'd20);
    pop(0, 11'd10);
    empty_ck(0);

    // push and pop in the same cycle
    push(0, 0, 11'sd3);
    push(0, 0, 11'sd4);
    rdy[0][0] = 1'b1;
    din[0][0] = 11'sd6;
    want("col_wait", 0);
    #1 got(rc[0]);
    want("col_offer", 32'(4'b0001 << mop));
    got(sd[0]);
    o = sd[0];
    @(negedge clk);
    dn[0] = o;
    want("col_acc", 4'b0001);
    #1 got(rc[0]);
    want("col_send", 0);
    got(sd[0]);
    @(negedge clk);
    dn[0]  = 4'b0000;
    rdy[0] = 4'b0000;
    pop(0, 11'd6);
    pop(0, 11'd3);
    empty_ck(0);

    // reset during a pending write
    push(0, 0, 11'sd7);
    rdy[0][0] = 1'b1;
    din[0][0] = 11'sd9;
    @(negedge clk);
    rst_n = 1'b0;
    want("mid_data", 0);
    #1 got({21'd0, od[0]});
    want("mid_recv", 0);
    got(rc[0]);
    want("mid_send", 0);
    got(sd[0]);
    @(negedge clk);
    rst_n = 1'b1;
    want("mid_rearm", 0);
    #1 got(rc[0]);
    @(negedge clk);
    want("mid_acc", 4'b0001);
    #1 got(rc[0]);
    @(negedge clk);
    rdy[0] = 4'b0000;
    pop(0, 11'd9);
    empty_ck(0);

    // full stack stalls writers on DEPTH=2
    push(1, 0, 11'sd7);
    push(1, 0, 11'sd8);
    rdy[1][3] = 1'b1;
    din[1][3] = 11'sd9;
    for (int k = 0; k < 4; k++) begin
      want("full_recv", 0);
      want("full_top", 8);
      #1 got(rc[1]);
      got({21'd0, od[1]});
      @(negedge clk);
    end
    want("full_offer", 32'(4'b0001 << mop));
    #1 got(sd[1]);
    o = sd[1];
    @(negedge clk);
    dn[1] = o;
    want("full_pop_recv", 0);
    #1 got(rc[1]);
    want("full_pop_send", 0);
    got(sd[1]);
    @(negedge clk);
    dn[1] = 4'b0000;
    want("full_acc", 4'b1000);
    #1 got(rc[1]);
    @(negedge clk);
    rdy[1] = 4'b0000;
    pop(1, 11'd9);
    pop(1, 11'd7);
    empty_ck(1);

    if (q.size() != 0) begin
      nfail++;
      $display("FAIL sb_leftover obs=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
